// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes, FSM states
// and the request legality check used at accept time.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // Misaligned halves/words, reserved size codes and unsigned stores are rejected.
  function automatic logic req_illegal(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = offset[0];
      F3_HU:   bad = we | offset[0];
      F3_W:    bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// master = core plus memory environment, slave = the load/store unit.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_write, mem_read
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_write, mem_read
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte/half lane extraction with sign or zero extension for loads, and
// read-modify-write merge of a byte/half into a memory word for stores.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] merged;

  always_comb begin
    byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'h000000, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'h0000, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the fetched word survives.
  always_comb begin
    merged = rdata_i;
    case (funct3_i)
      F3_B, F3_BU: merged[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
      F3_H, F3_HU: merged[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default:     merged = wdata_i;
    endcase
    merged_o = merged;
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core and a registered-read
// word memory; sub-word stores are done as read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        valid_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data_d;
  logic [31:0] merged_d;

  assign accept  = bus.req_valid && (state_q == ST_IDLE);
  assign req_err = req_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  lsu_lane_align u_lane_align (
    .funct3_i    (funct3_q),
    .offset_i    (addr_q[1:0]),
    .rdata_i     (bus.mem_rdata),
    .wdata_i     (wdata_q),
    .load_data_o (load_data_d),
    .merged_o    (merged_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            err_q    <= req_err;
            if (req_err) begin
              rdata_q <= 32'h0;
              valid_q <= 1'b1;
              state_q <= ST_RESP;
            end else if (!bus.req_we) begin
              state_q <= ST_RD;
            end else if (bus.req_funct3 == F3_W) begin
              state_q <= ST_WR;
            end else begin
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: state_q <= ST_WAIT;
        // Memory word is on mem_rdata here: finish a load or build the RMW word.
        ST_WAIT: begin
          if (we_q) begin
            wdata_q <= merged_d;
            state_q <= ST_WR;
          end else begin
            rdata_q <= load_data_d;
            valid_q <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_WR: begin
          valid_q <= 1'b1;
          state_q <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = valid_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata  = wdata_q;

  // Gated by rst directly so a reset landing mid-access suppresses it at once.
  assign bus.mem_read  = (state_q == ST_RD) && !rst;
  assign bus.mem_write = (state_q == ST_WR) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single transactions
// plus hand-written sequences for request-during-RESP and reset-during-WR.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        preEn;
    logic [31:0] preVal;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expRd;
    int          expWr;
    logic        memChk;
    logic [31:0] expMem;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:63];
  int          wrCount = 0;
  int          rdCount = 0;
  logic        clearMem;
  logic        preEn;
  logic [5:0]  preIdx;
  logic [31:0] preVal;

  // Registered-read word memory; preload/clear requests come from the test.
  always @(posedge clk) begin
    if (clearMem) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
    end else begin
      if (preEn) mem[preIdx] <= preVal;
      if (bus.mem_read) begin
        bus.mem_rdata <= mem[bus.mem_addr[7:2]];
        rdCount++;
      end
      if (bus.mem_write) begin
        mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        wrCount++;
      end
    end
  end

  int   nChecks = 0;
  int   nFails  = 0;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic pe, input logic [31:0] pv,
                              input logic [31:0] er, input logic ee, input int el,
                              input int erd, input int ewr,
                              input logic mc, input logic [31:0] em);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.preEn = pe; v.preVal = pv; v.expRdata = er; v.expErr = ee;
    v.expLat = el; v.expRd = erd; v.expWr = ewr; v.memChk = mc; v.expMem = em;
    return v;
  endfunction

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    preIdx = idx;
    preVal = val;
    preEn  = 1'b1;
    @(negedge clk);
    preEn  = 1'b0;
  endtask

  task automatic waitReady(input string name);
    int waitCnt = 0;
    @(negedge clk);
    while (!bus.req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput(name, 32'(waitCnt < 20), 32'd1);
  endtask

  // Issue one request, scramble the inputs after accept, measure latency.
  task automatic applyStimulus(input vec_t v, input string name, output int lat);
    waitReady({name, " ready"});
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~v.we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'h0BAD_0BAD;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    int   w0;
    int   r0;
    vec_t v;
    string nm;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    preEn = 1'b0; preIdx = 6'd0; preVal = 32'h0;
    clearMem = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready",  32'(bus.req_ready),  32'd1);
    checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset resp_err",   32'(bus.resp_err),   32'd0);
    checkOutput("reset resp_rdata", bus.resp_rdata,      32'h0);
    checkOutput("reset mem_read",   32'(bus.mem_read),   32'd0);
    checkOutput("reset mem_write",  32'(bus.mem_write),  32'd0);
    checkOutput("reset mem_addr",   bus.mem_addr,        32'h0);
    rst = 1'b0;
    clearMem = 1'b0;

    //          we    f3     addr    wdata        pre  preVal        expRdata      err lat rd wr mc expMem
    vecs.push_back(mk(1'b0, F3_B,  32'h11, 32'h0,        1, 32'h8899AABB, 32'hFFFFFFAA, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b0, F3_BU, 32'h11, 32'h0,        0, 0,            32'h000000AA, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b0, F3_H,  32'h12, 32'h0,        0, 0,            32'hFFFF8899, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b0, F3_HU, 32'h10, 32'h0,        0, 0,            32'h0000AABB, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b0, F3_W,  32'h10, 32'h0,        0, 0,            32'h8899AABB, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b0, F3_B,  32'h13, 32'h0,        0, 0,            32'hFFFFFF88, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b0, F3_BU, 32'h10, 32'h0,        0, 0,            32'h000000BB, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b1, F3_B,  32'h12, 32'hFFFFFF5C, 1, 32'h11223344, 32'h000000BB, 0, 4, 1, 1, 1, 32'h115C3344));
    vecs.push_back(mk(1'b0, F3_H,  32'h13, 32'h0,        0, 0,            32'h00000000, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, F3_W,  32'h20, 32'hDEADBEEF, 0, 0,            32'h00000000, 0, 2, 0, 1, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1'b0, F3_W,  32'h20, 32'h0,        0, 0,            32'hDEADBEEF, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b1, F3_H,  32'h02, 32'h1234BEEF, 1, 32'h00000000, 32'hDEADBEEF, 0, 4, 1, 1, 1, 32'hBEEF0000));
    vecs.push_back(mk(1'b0, F3_HU, 32'h02, 32'h0,        0, 0,            32'h0000BEEF, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b0, F3_H,  32'h02, 32'h0,        0, 0,            32'hFFFFBEEF, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b1, F3_B,  32'h03, 32'hFFFFFF12, 0, 0,            32'hFFFFBEEF, 0, 4, 1, 1, 1, 32'h12EF0000));
    vecs.push_back(mk(1'b1, F3_B,  32'h00, 32'h00000034, 0, 0,            32'hFFFFBEEF, 0, 4, 1, 1, 1, 32'h12EF0034));
    vecs.push_back(mk(1'b1, F3_H,  32'h00, 32'hAAAA7777, 0, 0,            32'hFFFFBEEF, 0, 4, 1, 1, 1, 32'h12EF7777));
    vecs.push_back(mk(1'b0, F3_B,  32'h01, 32'h0,        0, 0,            32'h00000077, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b0, F3_H,  32'h00, 32'h0,        0, 0,            32'h00007777, 0, 3, 1, 0, 0, 0));
    vecs.push_back(mk(1'b0, F3_W,  32'h22, 32'h0,        0, 0,            32'h00000000, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 3'b011, 32'h24, 32'h0,       0, 0,            32'h00000000, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, F3_BU, 32'h00, 32'h000000FF, 0, 0,            32'h00000000, 1, 1, 0, 0, 1, 32'h12EF7777));
    vecs.push_back(mk(1'b1, F3_HU, 32'h00, 32'h0000FFFF, 0, 0,            32'h00000000, 1, 1, 0, 0, 1, 32'h12EF7777));
    vecs.push_back(mk(1'b0, 3'b110, 32'h10, 32'h0,       0, 0,            32'h00000000, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 3'b111, 32'h10, 32'h0,       0, 0,            32'h00000000, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, F3_H,  32'h01, 32'h0000FFFF, 0, 0,            32'h00000000, 1, 1, 0, 0, 1, 32'h12EF7777));
    vecs.push_back(mk(1'b0, F3_HU, 32'h03, 32'h0,        0, 0,            32'h00000000, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, F3_W,  32'h10, 32'h0,        0, 0,            32'h115C3344, 0, 3, 1, 0, 0, 0));

    foreach (vecs[i]) begin
      v  = vecs[i];
      nm = $sformatf("v%0d", i);
      if (v.preEn) preload(v.addr[7:2], v.preVal);
      w0 = wrCount;
      r0 = rdCount;
      applyStimulus(v, nm, lat);
      checkOutput({nm, " latency"}, 32'(lat), 32'(v.expLat));
      checkOutput({nm, " resp_err"}, 32'(bus.resp_err), 32'(v.expErr));
      checkOutput({nm, " resp_rdata"}, bus.resp_rdata, v.expRdata);
      @(negedge clk);
      checkOutput({nm, " resp_valid pulse"}, 32'(bus.resp_valid), 32'd0);
      checkOutput({nm, " ready after resp"}, 32'(bus.req_ready), 32'd1);
      checkOutput({nm, " mem reads"}, 32'(rdCount - r0), 32'(v.expRd));
      checkOutput({nm, " mem writes"}, 32'(wrCount - w0), 32'(v.expWr));
      if (v.memChk) checkOutput({nm, " mem word"}, mem[v.addr[7:2]], v.expMem);
    end

    // A request held through WR/RESP is only taken once the unit is back in IDLE.
    waitReady("hold ready");
    bus.req_we = 1'b1; bus.req_funct3 = F3_W; bus.req_addr = 32'h30;
    bus.req_wdata = 32'h0000CAFE; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_we = 1'b0; bus.req_wdata = 32'h0;
    @(negedge clk);
    checkOutput("hold ready in WR", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("hold resp_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("hold ready in RESP", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("hold ready in IDLE", 32'(bus.req_ready), 32'd1);
    checkOutput("hold no early resp", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = c;
        break;
      end
    end
    checkOutput("hold load latency", 32'(lat), 32'd3);
    checkOutput("hold load rdata", bus.resp_rdata, 32'h0000CAFE);

    // Reset landing while the unit sits in WR must cancel the write.
    waitReady("rst ready");
    w0 = wrCount;
    bus.req_we = 1'b1; bus.req_funct3 = F3_W; bus.req_addr = 32'h30;
    bus.req_wdata = 32'h00000001; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst mem_write in WR", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst mem_write forced", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    checkOutput("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("rst resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("rst mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst ready after", 32'(bus.req_ready), 32'd1);
    checkOutput("rst no write", 32'(wrCount - w0), 32'd0);
    checkOutput("rst mem word", mem[6'd12], 32'h0000CAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  core requests a load/store.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  32  extended load data.
REQ-012 resp_err  out  1  misaligned or illegal request; valid with resp_valid.
REQ-013 mem_addr  out  32  word-aligned address {addr[31:2],2'b00} to the data memory.
REQ-014 mem_wdata  out  32  full word to write.
REQ-015 mem_write  out  1  memory write enable.
REQ-016 mem_read  out  1  memory read enable.
REQ-017 mem_rdata  in  32  memory data; valid the cycle after mem_read (registered read, word-only write).

Function
REQ-018 States SHALL be IDLE, RD, WAIT, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 On req_valid&req_ready, the unit SHALL latch we, funct3, addr and wdata; later input changes have no effect.
REQ-020 Err SHALL be raised for: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 011/110/111; stores with funct3 100/101.
REQ-021 Transitions from IDLE: err -> RESP; load -> RD; store W -> WR; store B/H -> RD.
REQ-022 RD -> WAIT; WAIT -> RESP for loads, WAIT -> WR for stores; WR -> RESP; RESP -> IDLE.
REQ-023 mem_read SHALL be 1 only in RD and mem_write only in WR, both decoded from registered state; no memory access SHALL occur on err.
REQ-024 In WAIT, a load SHALL register into resp_rdata the byte lane addr[1:0] or half lane addr[1], sign-extended for B/H and zero-extended for BU/HU; W passes through.
REQ-025 In WAIT, a B/H store SHALL merge req_wdata[7:0] or [15:0] into that lane of mem_rdata, other bytes unchanged (read-modify-write); W stores write req_wdata directly.
REQ-026 Latency from the accept edge to resp_valid high: 3 cycles for loads, 2 for SW, 4 for SB/SH, 1 for err.
REQ-027 resp_rdata SHALL hold its last load value across stores and SHALL be 0 when resp_err=1.
REQ-028 A request presented during RESP SHALL NOT be accepted; it is taken in the following IDLE cycle.
REQ-029 Back-to-back store then load to the same word SHALL return the stored data, since WR completes before the next RD.

Reset
REQ-030 While rst=1, mem_read and mem_write SHALL be forced to 0 combinationally, including mid-operation.
REQ-031 At the rst edge: state = IDLE, resp_valid = 0, resp_err = 0, resp_rdata = 0, latched registers = 0; the first cycle after reset has req_ready = 1.
REQ-032 A reset arriving in WR before the edge SHALL prevent that write.

Structure
REQ-033 The shared package SHALL hold the funct3 size constants and the state enum.
REQ-034 Lane extraction and merge SHALL live in one combinational sub-module, lsu_lane_align.

Verification
REQ-035 Scenario: mem[0x10] = 0x8899AABB; LB at 0x11 -> resp_rdata = 0xFFFFFFAA, 3 cycles after accept; LBU at 0x11 -> 0x000000AA.
REQ-036 Scenario: SB 0x5C to 0x12 over 0x11223344 -> memory word = 0x115C3344 with exactly one mem_write pulse; resp_valid 4 cycles after accept.
REQ-037 Scenario: LH at 0x13 -> resp_err = 1 and resp_rdata = 0 after 1 cycle, mem_read/mem_write never asserted.
REQ-038 Scenario: SW 0xDEADBEEF to 0x20, then immediate LW at 0x20 -> 0xDEADBEEF.
REQ-039 Scenario: rst raised while in WR for SW 0x1 to 0x30 -> mem[0x30] unchanged, outputs at reset values, req_ready = 1 on the next cycle.
REQ-040 Scenario: SH 0xBEEF to 0x02 over 0x00000000 -> word = 0xBEEF0000; LHU at 0x02 -> 0x0000BEEF; LH -> 0xFFFFBEEF.
